// File: rtl/nxn_switch_allocator_if.sv
// Handshake bundle between input buffers/routing, the switch allocator and the crossbar.
// Packed arrays keep the flat IN_N*W bit layout of the per-channel fields.
interface nxn_switch_allocator_if #(
  parameter int IN_N      = 5,
  parameter int OUT_M     = 5,
  parameter int FLIT_ID_W = 2
);
  localparam int DEST_W = $clog2(OUT_M);
  localparam int OWN_W  = $clog2(IN_N);

  logic [IN_N-1:0]                 valid_i;
  logic [IN_N-1:0][FLIT_ID_W-1:0]  flit_id_i;
  logic [IN_N-1:0][DEST_W-1:0]     dest_i;
  logic [OUT_M-1:0]                out_rdy_i;
  logic [IN_N-1:0]                 grant_o;
  logic [OUT_M-1:0]                valid_o;
  logic [OUT_M-1:0][OWN_W-1:0]     sel_o;

  modport master (
    output valid_i, flit_id_i, dest_i, out_rdy_i,
    input  grant_o, valid_o, sel_o
  );

  modport slave (
    input  valid_i, flit_id_i, dest_i, out_rdy_i,
    output grant_o, valid_o, sel_o
  );
endinterface

// File: rtl/nxn_switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter + lock FSM per output,
// driving crossbar selects, buffer pops and downstream valids.
module nxn_sa_out_arb #(
  parameter int IN_N  = 5,
  parameter int OWN_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IN_N-1:0]   cand,
  input  logic [IN_N-1:0]   src_vld,
  input  logic [IN_N-1:0]   src_tail,
  input  logic              out_rdy,
  output logic              xfer,
  output logic [OWN_W-1:0]  owner
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [OWN_W-1:0] ptr;
  logic [OWN_W-1:0] win;
  logic [OWN_W-1:0] ptr_nxt;
  logic [OWN_W:0]   idx_w;
  logic [OWN_W-1:0] idx;
  logic             found;

  // First candidate at or above ptr, wrapping past IN_N-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
    idx   = '0;
    for (int k = 0; k < IN_N; k++) begin
      idx_w = {1'b0, ptr} + (OWN_W+1)'(k);
      if (idx_w >= (OWN_W+1)'(IN_N)) idx_w = idx_w - (OWN_W+1)'(IN_N);
      idx = idx_w[OWN_W-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign ptr_nxt = (win == OWN_W'(IN_N-1)) ? '0 : win + 1'b1;
  assign xfer    = (state == LOCKED) && src_vld[owner] && out_rdy;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner <= win;
          ptr   <= ptr_nxt;
          state <= LOCKED;
        end
        LOCKED: if (xfer && src_tail[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module nxn_switch_allocator #(
  parameter int IN_N      = 5,
  parameter int OUT_M     = 5,
  parameter int FLIT_ID_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  nxn_switch_allocator_if.slave  sw
);
  localparam int DEST_W = $clog2(OUT_M);
  localparam int OWN_W  = $clog2(IN_N);

  // Flit type encoding: bit1 marks a packet start (HEAD/SINGLE), bit0 an end (TAIL/SINGLE).
  logic [IN_N-1:0]              is_head;
  logic [IN_N-1:0]              is_tail;
  logic [OUT_M-1:0][IN_N-1:0]   cand;
  logic [OUT_M-1:0]             xfer;
  logic [OUT_M-1:0][OWN_W-1:0]  owner;
  logic [IN_N-1:0]              grant;

  for (genvar i = 0; i < IN_N; i++) begin : g_in
    assign is_head[i] = sw.flit_id_i[i][1];
    assign is_tail[i] = sw.flit_id_i[i][0];
  end

  for (genvar o = 0; o < OUT_M; o++) begin : g_out
    for (genvar i = 0; i < IN_N; i++) begin : g_cand
      assign cand[o][i] = sw.valid_i[i] && is_head[i] && (sw.dest_i[i] == DEST_W'(o));
    end

    nxn_sa_out_arb #(.IN_N(IN_N), .OWN_W(OWN_W)) u_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .cand     (cand[o]),
      .src_vld  (sw.valid_i),
      .src_tail (is_tail),
      .out_rdy  (sw.out_rdy_i[o]),
      .xfer     (xfer[o]),
      .owner    (owner[o])
    );

    assign sw.sel_o[o] = owner[o];
  end

  // An input heads at most one packet, so at most one output can be popping it.
  always_comb begin
    grant = '0;
    for (int o = 0; o < OUT_M; o++)
      if (xfer[o]) grant[owner[o]] = 1'b1;
  end

  assign sw.grant_o = grant;
  assign sw.valid_o = xfer;
endmodule

// File: doc/nxn_switch_allocator.md
Name: nxn_switch_allocator

Overview:
- Control end of the NxN parallel crossbar. Generates the per-output select vector that steers input channels through the crossbar's output muxes.
- Performs wormhole allocation. Each output runs a round-robin arbiter over head flits addressed to it, then locks to the winner until that packet's tail flit passes.
- Sits between the input buffers/routing logic and the crossbar. It drives buffer pops (grant_o) and downstream valids.

Parameters:
- IN_N, 5, number of input channels
- OUT_M, 5, number of output channels
- FLIT_ID_W, 2, width of flit type field

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  IN_N  input i has a flit at its buffer head
- flit_id_i  in  IN_N*FLIT_ID_W  packed flit type per input. HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11
- dest_i  in  IN_N*$clog2(OUT_M)  packed requested output per input; meaningful only on HEAD/SINGLE
- out_rdy_i  in  OUT_M  downstream of output o can accept a flit
- grant_o  out  IN_N  input i's flit transfers this cycle (pop)
- valid_o  out  OUT_M  output o carries a valid flit this cycle
- sel_o  out  OUT_M*$clog2(IN_N)  packed crossbar select, field o = owning input index

Behaviour:
- Reset (rst_ni=0 at posedge): all outputs IDLE, owners 0, round-robin pointers 0. Reset applies mid-packet too; any lock is dropped.
- While state is at reset value: grant_o=0, valid_o=0, sel_o=0.
- Per-output FSM, IDLE/LOCKED; owner register is $clog2(IN_N) bits.
- IDLE:
  - Candidates are inputs with valid_i=1, flit type HEAD or SINGLE, and dest==o.
  - If any candidate exists, the next posedge latches winner->owner and enters LOCKED.
  - Winner = first candidate scanning from pointer upward, wrapping at IN_N-1->0. Pointer <= winner+1 mod IN_N.
  - No flit transfers in IDLE: valid_o[o]=0, sel_o field holds last owner.
- LOCKED:
  - sel_o field = owner.
  - Transfer when valid_i[owner] && out_rdy_i[o]. On transfer, valid_o[o]=1 and grant_o[owner]=1, combinationally in the same cycle.
  - dest_i is ignored in LOCKED.
  - Transfer of TAIL or SINGLE returns the FSM to IDLE at the next posedge. BODY/HEAD keep it LOCKED.
- Latency:
  - Head presented at cycle t (output IDLE) transfers at t+1 at the earliest.
  - Back-to-back packets to one output have exactly one idle cycle between the tail and the next head.
- Stalls: out_rdy_i=0 or valid_i[owner]=0 holds LOCKED with no grant; there is no timeout.
- Non-head flits from inputs not owning any output are ignored; no grant.
- Simultaneous requests:
  - Different outputs arbitrate independently and may lock in the same cycle.
  - One input can own at most one output, since only its current head flit requests.
- grant_o[i] is the OR over outputs owned by i; at most one is active.
- sel_o field width is $clog2(IN_N). The crossbar sel port matches when IN_N==OUT_M.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, all valid_i=0 -> grant_o=0, valid_o=0, sel_o=0 for all cycles.
- Single-flit path: input 2 SINGLE dest=3, out_rdy_i=all 1 -> cycle t+1: sel_o[3]=2, valid_o[3]=1, grant_o=5'b00100. Cycle t+2: output 3 IDLE, valid_o=0.
- Wormhole lock: input 1 sends HEAD,BODY,BODY,TAIL dest=0. Input 4 sends HEAD dest=0 from the same cycle.
  - Input 1 wins (pointer 0) and gets four consecutive grants.
  - Input 4 is locked one cycle after input 1's tail and is granted the cycle after that.
- Round-robin fairness: inputs 0,1,2 repeatedly send SINGLE dest=4 -> owner sequence 0,1,2,0,1,2, each grant separated by one idle cycle.
- Backpressure: locked to input 3 on output 1, out_rdy_i[1]=0 for 3 cycles -> grant_o[3]=0 and valid_o[1]=0 during the stall. Transfer resumes the first cycle out_rdy_i[1]=1, and sel_o[1] stays 3 throughout.
- Parallel plus reset: inputs 0->2 and 3->1 lock simultaneously, both granted the same cycle. Assert rst_ni=0 mid-packet -> next cycle all outputs IDLE, grant_o=0, sel_o=0.
